// File: rtl/fir_decim_buffer.sv
// Integrate-and-dump decimator for the FIR output stream, followed by a small
// first-word-fall-through FIFO presented on a valid/ready interface.
module fir_decim_buffer #(
  parameter int WIDTH      = 16,
  parameter int DECIM      = 4,
  parameter int LOG2_DECIM = 2,
  parameter int DEPTH      = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [LOG2_DEPTH:0]   fifo_count,
  output logic                  overflow
);

  // Handshake: a word moves to the sink on every rising edge where
  // dout_valid && dout_ready; dout_valid never depends on dout_ready, and the
  // FIR side has no back-pressure (din is taken whenever din_valid is high).

  localparam int AW = WIDTH + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] PHASE_LAST = LOG2_DECIM'(DECIM - 1);

  logic [AW-1:0]         r_acc;
  logic [LOG2_DECIM-1:0] r_phase;
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [LOG2_DEPTH:0]   r_wptr;
  logic [LOG2_DEPTH:0]   r_rptr;
  logic [WIDTH-1:0]      r_last;
  logic                  r_overflow;

  logic [AW-1:0]         w_sum;
  logic [WIDTH-1:0]      w_result;
  logic                  w_dump;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic [LOG2_DEPTH-1:0] w_widx;
  logic [LOG2_DEPTH-1:0] w_ridx;

  assign w_sum    = r_acc + {{LOG2_DECIM{1'b0}}, din};
  // Dropping the low guard bits is the truncating divide by DECIM.
  assign w_result = w_sum[AW-1:LOG2_DECIM];
  assign w_dump   = din_valid && (r_phase == PHASE_LAST);

  assign w_widx  = r_wptr[LOG2_DEPTH-1:0];
  assign w_ridx  = r_rptr[LOG2_DEPTH-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[LOG2_DEPTH] != r_rptr[LOG2_DEPTH]) && (w_widx == w_ridx);
  assign w_pop   = !w_empty && dout_ready;
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign w_push  = w_dump && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc      <= '0;
      r_phase    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_last     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (din_valid) begin
        if (w_dump) begin
          r_acc   <= '0;
          r_phase <= '0;
        end else begin
          r_acc   <= w_sum;
          r_phase <= r_phase + LOG2_DECIM'(1);
        end
      end
      if (w_push) begin
        r_wptr <= r_wptr + (LOG2_DEPTH + 1)'(1);
      end else if (w_dump) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_last <= r_mem[w_ridx];
        r_rptr <= r_rptr + (LOG2_DEPTH + 1)'(1);
      end
    end
  end

  // Storage needs no reset: it is only observable through the pointers.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[w_widx] <= w_result;
    end
  end

  assign dout       = w_empty ? r_last : r_mem[w_ridx];
  assign dout_valid = !w_empty;
  assign fifo_count = r_wptr - r_rptr;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Randomised and directed bench for fir_decim_buffer: block-average reference
// model feeding an expected queue, checked by an independent negedge monitor.
module tb_fir_decim_buffer;

  localparam int WIDTH      = 16;
  localparam int DECIM      = 4;
  localparam int LOG2_DECIM = 2;
  localparam int DEPTH      = 4;
  localparam int LOG2_DEPTH = 2;

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [LOG2_DEPTH:0]  fifo_count;
  logic                 overflow;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 0;

  // Reference model state.
  logic [WIDTH-1:0] exp_q[$];
  int               m_sum;
  int               m_n;
  int               m_cnt;
  bit               m_ovf;
  logic [WIDTH-1:0] exp_last;

  fir_decim_buffer #(
    .WIDTH(WIDTH), .DECIM(DECIM), .LOG2_DECIM(LOG2_DECIM),
    .DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: block sums divided by DECIM, occupancy limited to DEPTH.
  always @(posedge clk) begin
    if (!rst) begin
      m_sum = 0;
      m_n   = 0;
      m_cnt = 0;
      m_ovf = 0;
      exp_q.delete();
    end else begin
      bit pop_m;
      bit dump_m;
      int res;
      pop_m  = (m_cnt > 0) && dout_ready;
      dump_m = 0;
      res    = 0;
      if (din_valid) begin
        m_sum = m_sum + int'(din);
        m_n   = m_n + 1;
        if (m_n == DECIM) begin
          dump_m = 1;
          res    = m_sum / DECIM;
          m_sum  = 0;
          m_n    = 0;
        end
      end
      if (pop_m) m_cnt = m_cnt - 1;
      if (dump_m) begin
        if (m_cnt < DEPTH) begin
          exp_q.push_back(WIDTH'(res));
          m_cnt = m_cnt + 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares the DUT against the model away from the edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("fifo_count", int'(fifo_count), m_cnt);
      check("dout_valid", int'(dout_valid), int'(m_cnt > 0));
      check("overflow", int'(overflow), int'(m_ovf));
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check("exp_q_nonempty", 0, 1);
        end else begin
          check("dout_head", int'(dout), int'(exp_q[0]));
          if (dout_ready && rst) exp_last = exp_q.pop_front();
        end
      end else begin
        check("dout_hold", int'(dout), int'(exp_last));
      end
      if (!rst) exp_last = '0;
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic drive(input bit v, input int d, input bit rdy);
    @(posedge clk);
    #1;
    din_valid  = v;
    din        = WIDTH'(d);
    dout_ready = rdy;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic block(input int d, input bit rdy);
    for (int i = 0; i < DECIM; i++) drive(1, d, rdy);
  endtask

  initial begin
    rst        = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    exp_last   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1;
    @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_count", int'(fifo_count), 0);

    // Basic average and its latency.
    drive(1, 100, 1); drive(1, 200, 1); drive(1, 300, 1); drive(1, 400, 1);
    drive(0, 0, 1);
    @(negedge clk);
    check("avg_valid", int'(dout_valid), 1);
    check("avg_dout", int'(dout), 250);
    drive(0, 0, 1);
    @(negedge clk);
    check("avg_popped", int'(dout_valid), 0);
    check("avg_hold", int'(dout), 250);

    // Full scale and truncation.
    block(16'hFFFF, 1);
    drive(0, 0, 1);
    @(negedge clk);
    check("fullscale", int'(dout), 16'hFFFF);
    drive(1, 1, 1); drive(1, 1, 1); drive(1, 1, 1); drive(1, 0, 1);
    drive(0, 0, 1);
    @(negedge clk);
    check("trunc", int'(dout), 0);
    repeat (2) drive(0, 0, 1);

    // Gapped valid.
    for (int i = 0; i < DECIM; i++) begin
      drive(1, 8, 1);
      repeat (3) drive(0, 0, 1);
    end
    repeat (2) drive(0, 0, 1);

    // Overflow while stalled, then drain.
    for (int i = 0; i < 20; i++) drive(1, 40, 0);
    drive(0, 0, 0);
    @(negedge clk);
    check("ovf_count", int'(fifo_count), DEPTH);
    check("ovf_flag", int'(overflow), 1);
    repeat (6) drive(0, 0, 1);
    @(negedge clk);
    check("drain_count", int'(fifo_count), 0);
    check("ovf_sticky", int'(overflow), 1);

    // Push and pop together while full.
    do_reset(1);
    block(10, 0); block(20, 0); block(30, 0); block(40, 0);
    drive(1, 50, 0); drive(1, 50, 0); drive(1, 50, 0); drive(1, 50, 1);
    drive(0, 0, 0);
    @(negedge clk);
    check("pp_count", int'(fifo_count), DEPTH);
    check("pp_ovf", int'(overflow), 0);
    check("pp_head", int'(dout), 20);
    repeat (6) drive(0, 0, 1);

    // Reset mid-block.
    drive(1, 1000, 1); drive(1, 1000, 1);
    do_reset(1);
    block(8, 1);
    drive(0, 0, 1);
    @(negedge clk);
    check("midrst_dout", int'(dout), 8);
    repeat (2) drive(0, 0, 1);

    // Reset with data buffered.
    block(77, 0); block(99, 0);
    do_reset(1);
    @(negedge clk);
    check("rstfull_valid", int'(dout_valid), 0);
    check("rstfull_count", int'(fifo_count), 0);

    // Random traffic across pointer wraps, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 65535),
              $urandom_range(0, 2) == 0);
      end
    end
    repeat (10) drive(0, 0, 1);
    @(negedge clk);
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_decim_buffer.md
Name: fir_decim_buffer

Overview:
- Downstream consumer of the 16-bit FIR filter output (filterfir dataout).
- Decimates the filtered stream by DECIM using integrate-and-dump averaging.
- Buffers the decimated samples in a small first-word-fall-through FIFO.
- Presents them on a valid/ready interface to the next sink (DAC/serialiser stage).

Parameters:
- WIDTH, 16: sample width of din and dout.
- DECIM, 4: decimation factor; must be a power of two, at least 2.
- LOG2_DECIM, 2: log2(DECIM); sets the accumulator guard bits and the averaging shift.
- DEPTH, 4: number of FIFO entries; must be a power of two.
- LOG2_DEPTH, 2: log2(DEPTH).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-low reset; state resets when rst==0 at a clk rising edge.
- din, input, WIDTH: filtered sample from the FIR stage; unsigned.
- din_valid, input, 1: din is a new sample this cycle; no back-pressure toward the FIR.
- dout, output, WIDTH: decimated sample at the FIFO head.
- dout_valid, output, 1: FIFO is non-empty.
- dout_ready, input, 1: sink accepts dout this cycle.
- fifo_count, output, LOG2_DEPTH+1: current FIFO occupancy, 0..DEPTH.
- overflow, output, 1: sticky flag; set when a decimated result is dropped.

Behaviour:
- Reset (rst==0 at a clk edge):
  - acc, phase counter, FIFO pointers and fifo_count all go to 0.
  - dout=0, dout_valid=0, overflow=0.
  - Any partial accumulation and all buffered data are discarded; reset mid-block is legal.
- Accumulator:
  - acc is WIDTH+LOG2_DECIM bits wide and never saturates; 4 x 0xFFFF = 0x3FFFC fits in 18 bits.
  - The phase counter runs 0..DECIM-1 and advances only on cycles with din_valid=1.
  - Cycles with din_valid=0 leave acc and phase unchanged; gaps of any length are allowed.
  - din_valid=1 with phase<DECIM-1: acc <= acc + din; phase <= phase+1.
  - din_valid=1 with phase==DECIM-1 (dump cycle):
    - result = (acc + din) >> LOG2_DECIM, truncated with no rounding; this matches the shift-based coefficient arithmetic.
    - Result is pushed to the FIFO; acc <= 0; phase <= 0.
- FIFO:
  - Circular buffer of DEPTH entries with LOG2_DEPTH+1-bit read and write pointers; full/empty are distinguished by the MSB.
  - A pop occurs on any cycle with dout_valid=1 and dout_ready=1; the read pointer advances.
  - dout_ready while empty has no effect.
  - First-word fall-through: dout is always the entry at the head.
  - When empty, dout holds the last popped value (0 after reset), and dout_valid=0.
- Latency: a result pushed on a dump cycle at edge N is visible with dout_valid=1 after edge N. A sink can therefore take it on the next cycle.
- Full and simultaneous events:
  - Push while full with no pop: result is dropped, overflow <= 1, FIFO unchanged.
  - Push and pop in the same cycle while full: the pop frees a slot, the push is accepted, and fifo_count stays at DEPTH.
  - Push and pop in the same cycle at any other occupancy: fifo_count is unchanged.
  - Push into an empty FIFO with dout_ready=1: no same-cycle bypass; the entry becomes visible next cycle.
- overflow clears only on reset.
- Pointer wrap: pointers wrap modulo 2*DEPTH; the sequence order of entries is preserved across the wrap.

Test Plan:
- Basic average: after reset, din=100,200,300,400 on consecutive valid cycles, dout_ready=1 → one cycle after the 4th sample, dout_valid=1 and dout=250. It pops on the next cycle, then dout_valid=0.
- Full scale with truncation:
  - 4 x din=0xFFFF → dout=0xFFFF.
  - din=1,1,1,0 → dout=0, since 3>>2 truncates.
- Gapped valid: samples 8,8,8,8 with din_valid low for 3 cycles between each → exactly one output of 8, produced after the 4th valid sample.
- Overflow and full: dout_ready=0, 20 valid samples all equal to 40 → fifo_count=4 and overflow=1. Releasing dout_ready then yields four outputs of 40 and fifo_count=0; overflow stays 1.
- Push/pop at full: FIFO holds 4 entries and a dump cycle coincides with dout_ready=1 → fifo_count stays 4, overflow stays 0, and the new value reaches the head after 3 further pops.
- Mid-operation reset:
  - 2 samples of 1000, then rst=0 for one cycle, then 4 samples of 8 → output 8, not a value including 1000.
  - Reset while the FIFO is non-empty → dout_valid=0 and fifo_count=0 the next cycle.
